s_axis_load_sched: RTL and testbench

S_AXIS_LOAD_SCHED -- requirements
Module: s_axis_load_sched

---
 rtl/s_axis_load_sched.sv | 111 +++++++++++
 tb/tb_s_axis_load_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/s_axis_load_sched.sv
// s_axis_load_sched: round-robin scheduler sharing one AXI-Stream slave among load requesters.
// Optional watchdog enabled by defining S_AXIS_LOAD_SCHED_TIMEOUT_EN.
module s_axis_load_sched #(
  parameter int C_REQ_NUM  = 3,
  parameter int C_PAD_WDT  = 8,
  parameter int C_VCNT_WDT = 16,
  parameter int C_TOUT_WDT = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_REQ_NUM-1:0]            req_valid,
  input  logic [C_REQ_NUM*C_PAD_WDT-1:0]  req_padding,
  input  logic [C_REQ_NUM*C_VCNT_WDT-1:0] req_vect_cnt,
  output logic [C_REQ_NUM-1:0]            req_ready,
  output logic [C_REQ_NUM-1:0]            req_done,
  output logic [C_REQ_NUM-1:0]            req_err,
  output logic                            sx_start,
  output logic                            sx_en,
  output logic [C_PAD_WDT-1:0]            sx_padding,
  input  logic                            sx_done,
  input  logic                            sx_vect_val,
  input  logic                            sx_vect_last,
  output logic [$clog2(C_REQ_NUM)-1:0]    grant_id,
  output logic                            busy
);
  localparam int GW = $clog2(C_REQ_NUM);
  typedef enum logic [2:0] {IDLE, GRANT, START, RUN, REPORT} state_t;
  state_t state, nxt;
  logic [GW-1:0] last_grant, win;
  logic hit, last_cur, early, tout, wd_fire;
  logic [C_VCNT_WDT-1:0] cnt, vcnt;
  logic [C_REQ_NUM-1:0] one_hot;
  assign one_hot = C_REQ_NUM'(1) << grant_id;
  // Walk offsets downward so the nearest requester after last_grant wins
  always_comb begin
    win = last_grant;
    hit = 1'b0;
    for (int i = C_REQ_NUM; i >= 1; i--)
      if (req_valid[(int'(last_grant) + i) % C_REQ_NUM]) begin
        win = GW'((int'(last_grant) + i) % C_REQ_NUM);
        hit = 1'b1;
      end
  end
`ifdef S_AXIS_LOAD_SCHED_TIMEOUT_EN
  logic [C_TOUT_WDT-1:0] wd;
  assign wd_fire = state == RUN && !sx_vect_val && &wd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd   <= '0;
      tout <= 1'b0;
    end else if (state == START) begin
      wd   <= '0;
      tout <= 1'b0;
    end else if (state == RUN) begin
      wd   <= sx_vect_val ? '0 : wd + 1'b1;
      tout <= tout | (wd_fire && !sx_done);
    end
`else
  assign wd_fire = 1'b0;
  assign tout    = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:   nxt = |req_valid ? GRANT : IDLE;
      GRANT:  nxt = hit ? START : IDLE;
      START:  nxt = RUN;
      RUN:    nxt = (sx_done || wd_fire) ? REPORT : RUN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy     = state != IDLE;
    sx_en    = state == START || state == RUN;
    req_done = state == REPORT ? one_hot : '0;
    req_err  = (state == REPORT && (tout || cnt != vcnt || !last_cur || early)) ? one_hot : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_id   <= GW'(C_REQ_NUM - 1);
      last_grant <= GW'(C_REQ_NUM - 1);
      sx_padding <= '0;
      vcnt       <= '0;
      cnt        <= '0;
      last_cur   <= 1'b0;
      early      <= 1'b0;
      req_ready  <= '0;
      sx_start   <= 1'b0;
    end else begin
      req_ready <= (state == GRANT && hit) ? C_REQ_NUM'(1) << win : '0;
      sx_start  <= state == START;
      if (state == GRANT && hit) begin
        grant_id   <= win;
        sx_padding <= req_padding[win*C_PAD_WDT +: C_PAD_WDT];
        vcnt       <= req_vect_cnt[win*C_VCNT_WDT +: C_VCNT_WDT];
      end
      if (state == START) begin
        cnt      <= '0;
        last_cur <= 1'b0;
        early    <= 1'b0;
      end else if (state == RUN && sx_vect_val) begin
        cnt      <= &cnt ? cnt : cnt + 1'b1;
        last_cur <= sx_vect_last;
        early    <= early | last_cur;
      end
      if (state == REPORT) last_grant <= grant_id;
    end
endmodule

// File: tb/tb_s_axis_load_sched.sv
// tb_s_axis_load_sched: directed self-checking bench for s_axis_load_sched.
module tb_s_axis_load_sched;
  logic clk = 0, rst = 1;
  logic [2:0] req_valid = 0, req_ready, req_done, req_err;
  logic [23:0] req_padding = 0;
  logic [47:0] req_vect_cnt = 0;
  logic sx_start, sx_en, sx_done = 0, sx_vect_val = 0, sx_vect_last = 0, busy;
  logic [7:0] sx_padding;
  logic [1:0] grant_id;
  int checks = 0, failures = 0;
  s_axis_load_sched #(.C_REQ_NUM(3), .C_PAD_WDT(8), .C_VCNT_WDT(16), .C_TOUT_WDT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_padding(req_padding),
    .req_vect_cnt(req_vect_cnt), .req_ready(req_ready), .req_done(req_done),
    .req_err(req_err), .sx_start(sx_start), .sx_en(sx_en), .sx_padding(sx_padding),
    .sx_done(sx_done), .sx_vect_val(sx_vect_val), .sx_vect_last(sx_vect_last),
    .grant_id(grant_id), .busy(busy));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_vecs(input int n, input int lp);
    for (int i = 1; i <= n; i++) begin
      sx_vect_val  = 1;
      sx_vect_last = (i == lp);
      tick;
    end
    sx_vect_val  = 0;
    sx_vect_last = 0;
    sx_done      = 1;
    tick;
    sx_done = 0;
  endtask
  task automatic serve(input int id, input int n, input int lp, input logic experr, input logic drop);
    logic [7:0] pad;
    pad = req_padding[8*id +: 8];
    tick;
    chk("grant_busy", 32'(busy), 1);
    chk("grant_rdy_low", 32'(req_ready), 0);
    tick;
    chk("ready", 32'(req_ready), 32'(1) << id);
    chk("grant_id", 32'(grant_id), id);
    chk("padding", 32'(sx_padding), 32'(pad));
    chk("en_start", 32'(sx_en), 1);
    chk("start_low", 32'(sx_start), 0);
    if (drop) req_valid[id] = 0;
    tick;
    chk("sx_start", 32'(sx_start), 1);
    chk("ready_pulse", 32'(req_ready), 0);
    run_vecs(n, lp);
    chk("done", 32'(req_done), 32'(1) << id);
    chk("err", 32'(req_err), experr ? 32'(1) << id : 0);
    chk("en_report", 32'(sx_en), 0);
    tick;
    chk("done_pulse", 32'(req_done), 0);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_grant_id", 32'(grant_id), 2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_pad", 32'(sx_padding), 0);
    chk("rst_en", 32'(sx_en), 0);
    chk("rst_start", 32'(sx_start), 0);
    chk("rst_done", 32'(req_done), 0);
    rst = 0;
    sx_done = 1;
    tick;
    sx_done = 0;
    chk("idle_done_ign", 32'(busy), 0);
    chk("idle_done_pulse", 32'(req_done), 0);
    req_padding[15:8]   = 8'd2;
    req_vect_cnt[31:16] = 16'd4;
    req_valid = 3'b010;
    serve(1, 4, 4, 0, 1);
    tick;
    chk("single_idle", 32'(busy), 0);
    rst = 1;
    tick;
    rst = 0;
    req_padding  = {8'h12, 8'h11, 8'h10};
    req_vect_cnt = {16'd2, 16'd2, 16'd2};
    req_valid = 3'b111;
    serve(0, 2, 2, 0, 0);
    serve(1, 2, 2, 0, 0);
    serve(2, 2, 2, 0, 0);
    serve(0, 2, 2, 0, 0);
    req_valid = 0;
    req_vect_cnt[15:0] = 16'd5;
    req_valid = 3'b001;
    serve(0, 3, 3, 1, 1);
    req_vect_cnt[47:32] = 16'd4;
    req_valid = 3'b100;
    serve(2, 4, 2, 1, 1);
    req_vect_cnt[31:16] = 16'd4;
    req_valid = 3'b010;
    tick;
    tick;
    tick;
    sx_vect_val = 1;
    tick;
    tick;
    sx_vect_val = 0;
    rst = 1;
    #1;
    chk("rr_busy", 32'(busy), 0);
    chk("rr_en", 32'(sx_en), 0);
    chk("rr_done", 32'(req_done), 0);
    chk("rr_err", 32'(req_err), 0);
    chk("rr_grant_id", 32'(grant_id), 2);
    chk("rr_pad", 32'(sx_padding), 0);
    chk("rr_start", 32'(sx_start), 0);
    tick;
    chk("rr_no_done", 32'(req_done), 0);
    rst = 0;
    serve(1, 4, 4, 0, 1);
`ifdef S_AXIS_LOAD_SCHED_TIMEOUT_EN
    begin
      int k;
      k = 0;
      req_vect_cnt[15:0] = 16'd4;
      req_valid = 3'b001;
      tick;
      tick;
      tick;
      req_valid = 0;
      while (req_done == 0 && k < 40) begin
        tick;
        k++;
      end
      chk("tout_cycles", 32'(k), 16);
      chk("tout_done", 32'(req_done), 1);
      chk("tout_err", 32'(req_err), 1);
      chk("tout_en", 32'(sx_en), 0);
      tick;
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
